// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and the access legality rule for the
// two-master data-memory arbiter.
package dmem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Misaligned, unsupported width, or word index beyond the memory.
    function automatic logic access_illegal(input logic [1:0]  size,
                                            input logic [31:0] addr,
                                            input logic [31:0] depth_words);
        logic bad_s;
        case (size)
            SIZE_WORD: bad_s = (addr[1:0] != 2'b00);
            SIZE_HALF: bad_s = addr[0];
            SIZE_BYTE: bad_s = 1'b0;
            default:   bad_s = 1'b1;
        endcase
        return bad_s | ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master-side request/response channel of the data-memory arbiter.
interface dmem_arbiter_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, is_unsigned, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, size, is_unsigned, addr, wdata,
        output ack, rdata, err
    );

endinterface

// File: rtl/dmem_load_ext.sv
// Sign/zero extension of DMEM read data according to access width.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] dout32,
    input  logic [15:0] dout16,
    input  logic [7:0]  dout8,
    output logic [31:0] data
);

    // Width-dependent extension; illegal width yields zero
    always_comb begin
        data = 32'h0000_0000;
        case (size)
            SIZE_WORD: data = dout32;
            SIZE_HALF: data = {{16{dout16[15] & ~is_unsigned}}, dout16};
            SIZE_BYTE: data = {{24{dout8[7] & ~is_unsigned}}, dout8};
            default:   data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and single-access sequencer sharing one DMEM port
// between the load/store unit (m0) and a secondary master (m1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic        RESET_LAST  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          dmem_ena,
    output logic          dmem_wr,
    output logic [1:0]    dmem_w,
    output logic [31:0]   dmem_addr,
    output logic [31:0]   dmem_din32,
    output logic [15:0]   dmem_din16,
    output logic [7:0]    dmem_din8,
    input  logic [31:0]   dmem_dout32,
    input  logic [15:0]   dmem_dout16,
    input  logic [7:0]    dmem_dout8
);

    state_t      state_r;
    logic        last_r, gnt_r, we_r, uns_r, ena_r, wr_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;
    logic        ack0_r, ack1_r, err0_r, err1_r;
    logic [31:0] rdata0_r, rdata1_r;

    logic        any_req_s, gnt_s, sel_we_s, sel_uns_s, illegal_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_addr_s, sel_wdata_s, ext_s;

    // Pick the winner (round-robin on a tie) and mux its request fields
    always_comb begin
        any_req_s = m0.req | m1.req;
        gnt_s     = 1'b0;
        if (m0.req && m1.req) begin
            gnt_s = ~last_r;
        end else if (m1.req) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        if (gnt_s) begin
            sel_we_s    = m1.we;
            sel_size_s  = m1.size;
            sel_uns_s   = m1.is_unsigned;
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_we_s    = m0.we;
            sel_size_s  = m0.size;
            sel_uns_s   = m0.is_unsigned;
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
        end
        illegal_s = access_illegal(sel_size_s, sel_addr_s, DEPTH_WORDS);
    end

    dmem_load_ext u_load_ext (
        .size        (size_r),
        .is_unsigned (uns_r),
        .dout32      (dmem_dout32),
        .dout16      (dmem_dout16),
        .dout8       (dmem_dout8),
        .data        (ext_s)
    );

    // Sequencer FSM: latch request, one DMEM cycle, one response cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            last_r   <= RESET_LAST;
            gnt_r    <= 1'b0;
            we_r     <= 1'b0;
            uns_r    <= 1'b0;
            size_r   <= 2'b00;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            ena_r    <= 1'b0;
            wr_r     <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            err0_r   <= 1'b0;
            err1_r   <= 1'b0;
            rdata0_r <= 32'h0000_0000;
            rdata1_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt_r   <= gnt_s;
                        last_r  <= gnt_s;
                        we_r    <= sel_we_s;
                        size_r  <= sel_size_s;
                        uns_r   <= sel_uns_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                        if (illegal_s) begin
                            state_r <= ST_RESP;
                            ack0_r  <= ~gnt_s;
                            ack1_r  <= gnt_s;
                            err0_r  <= ~gnt_s;
                            err1_r  <= gnt_s;
                        end else begin
                            state_r <= ST_ACCESS;
                            ena_r   <= 1'b1;
                            wr_r    <= sel_we_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r  <= ST_RESP;
                    ena_r    <= 1'b0;
                    wr_r     <= 1'b0;
                    ack0_r   <= ~gnt_r;
                    ack1_r   <= gnt_r;
                    rdata0_r <= (!gnt_r && !we_r) ? ext_s : 32'h0000_0000;
                    rdata1_r <= (gnt_r && !we_r) ? ext_s : 32'h0000_0000;
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    err0_r   <= 1'b0;
                    err1_r   <= 1'b0;
                    rdata0_r <= 32'h0000_0000;
                    rdata1_r <= 32'h0000_0000;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ena_r    <= 1'b0;
                    wr_r     <= 1'b0;
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    err0_r   <= 1'b0;
                    err1_r   <= 1'b0;
                    rdata0_r <= 32'h0000_0000;
                    rdata1_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign dmem_ena   = ena_r;
    assign dmem_wr    = wr_r;
    assign dmem_w     = size_r;
    assign dmem_addr  = addr_r;
    assign dmem_din32 = wdata_r;
    assign dmem_din16 = wdata_r[15:0];
    assign dmem_din8  = wdata_r[7:0];

    assign m0.ack   = ack0_r;
    assign m0.err   = err0_r;
    assign m0.rdata = rdata0_r;
    assign m1.ack   = ack1_r;
    assign m1.err   = err1_r;
    assign m1.rdata = rdata1_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the byte/half/word data memory (`w`: 00 word, 01 half, 10 byte).
- Shares the single DMEM port between the CPU load/store unit (m0) and a secondary master such as debug or DMA (m1).
- Checks alignment and range, sequences one DMEM access per transaction, and returns sign- or zero-extended load data through a req/ack handshake.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in DMEM; word index = addr[31:2].
- RESET_LAST, 1: initial value of the last-grant register, so m0 wins the first tie.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mN_req  in  1  request, N in {0,1}; held high until mN_ack.
- mN_we  in  1  1 = store, 0 = load.
- mN_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
- mN_unsigned  in  1  zero-extend loads (lbu/lhu).
- mN_addr  in  32  byte address.
- mN_wdata  in  32  store data, right-aligned.
- mN_ack  out  1  one-cycle completion pulse.
- mN_rdata  out  32  extended load data; valid while mN_ack = 1.
- mN_err  out  1  misaligned, illegal size or out-of-range; valid while mN_ack = 1.
- dmem_ena  out  1  DMEM enable.
- dmem_wr  out  1  DMEM write strobe.
- dmem_w  out  2  DMEM width select, same encoding as mN_size.
- dmem_addr  out  32  DMEM byte address.
- dmem_din32 / dmem_din16 / dmem_din8  out  32/16/8  wdata, wdata[15:0], wdata[7:0].
- dmem_dout32 / dmem_dout16 / dmem_dout8  in  32/16/8  combinational DMEM read data.

Behaviour:
- FSM states:
  - IDLE: sample requests. If any is pending, latch the winner's we/size/unsigned/addr/wdata and its id.
    - If the latched request is illegal, go to RESP with err pending.
    - Otherwise go to ACCESS.
  - ACCESS: dmem_ena = 1, dmem_wr = latched we, dmem_w = latched size, dmem_addr = latched addr.
    - For loads, capture dmem_dout32/16/8 into a data register at the closing edge.
    - Always go to RESP.
  - RESP: assert ack, rdata and err for the granted master only, for one cycle, then go to IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the master not granted last wins (round-robin).
  - last_grant updates when a request is latched in IDLE.
- Legality: illegal = any of the following. Illegal requests never assert dmem_ena and leave memory unchanged.
  - size = 11.
  - size = 01 with addr[0] = 1.
  - size = 00 with addr[1:0] != 00.
  - addr[31:2] >= DEPTH_WORDS.
- Latency:
  - Legal access: req sampled at edge k; ACCESS is cycle k+1; ack in cycle k+2.
  - Illegal access: ack in cycle k+1.
  - Peak throughput: one legal transaction per 3 cycles.
- Handshake:
  - The master deasserts req in the cycle after ack.
  - If req is still high when the FSM is back in IDLE, it is a new transaction.
  - A losing master keeps req high and is served next.
- Load extension:
  - byte: dout8, sign-extended from bit 7 unless unsigned.
  - half: dout16, sign-extended from bit 15 unless unsigned.
  - word: dout32 as-is.
  - Stores and errored requests return rdata = 0.
- Output timing: DMEM outputs are decoded from the state register and latched fields only; there is no combinational path from mN_* inputs to any output.
- Reset values:
  - state = IDLE, last_grant = RESET_LAST.
  - All acks/errs 0, rdata 0, dmem_ena 0, dmem_wr 0, dmem_w 00, dmem_addr 0, din* 0.
- Reset mid-operation: rst during ACCESS drops dmem_ena immediately, so no write commits. The pending transaction is discarded with no ack and the master must re-request.

Decomposition:
- dmem_pkg holds:
  - Constants SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10, SIZE_BAD = 2'b11.
  - State encoding ST_IDLE, ST_ACCESS, ST_RESP.
  - A legality-check function.
- One sub-module, dmem_load_ext: combinational size/unsigned-driven extension of the captured read data.

Test Plan:
- m0 store word 0xDEADBEEF @0x10, then load word @0x10 -> dmem_ena/dmem_wr high for exactly one cycle; ack 2 cycles after sampling; rdata = 0xDEADBEEF, err = 0.
- Store byte 0x80 @0x13, then lb and lbu @0x13 -> rdata 0xFFFFFF80 and 0x00000080; bytes 0x10..0x12 unchanged.
- m0 and m1 both hold req for 4 transactions -> grants alternate m0, m1, m0, m1; no ack is ever given to the non-granted master.
- lh @0x21, lw @0x22, size = 11, lw @(DEPTH_WORDS*4) -> ack 1 cycle after sampling with err = 1, rdata = 0, dmem_ena never asserted.
- Assert rst during the ACCESS cycle of sw 0x12345678 @0x40 -> outputs return to reset values; a later lw @0x40 returns the prior contents, no ack for the aborted transaction.
